// File: rtl/key_evolution_if.sv
// Handshake bundle between the key source and the Anubis key-evolution engine.
// The engine side uses the slave modport; whoever starts a schedule uses master.
interface key_evolution_if;
    logic         start;
    logic [127:0] cipher_key;
    logic [127:0] evolutioned_key;
    logic [3:0]   round_num;
    logic [3:0]   counter;
    logic         load_key;
    logic         busy;
    logic         done;

    modport master (
        output start, cipher_key,
        input  evolutioned_key, round_num, counter, load_key, busy, done
    );

    modport slave (
        input  start, cipher_key,
        output evolutioned_key, round_num, counter, load_key, busy, done
    );
endinterface

// File: rtl/key_evolution.sv
// Anubis 128-bit key evolution (N = 4, R = 12): emits K^0..K^12, one per 16-cycle slot,
// together with the counter / round_num / load_key timing consumed by key_selection.

// Byte-wise Anubis S-box built from the P and Q 4-bit mini-boxes.
module gamma #(
    parameter int BYTES = 16
) (
    input  logic [8*BYTES-1:0] a,
    output logic [8*BYTES-1:0] b
);
    localparam logic [63:0] P_BOX = 64'h3FE0_54BC_DA96_7821;
    localparam logic [63:0] Q_BOX = 64'h9E56_A23C_F04D_7B18;

    function automatic logic [3:0] mini_p(input logic [3:0] x);
        return P_BOX[63 - 4*int'(x) -: 4];
    endfunction

    function automatic logic [3:0] mini_q(input logic [3:0] x);
        return Q_BOX[63 - 4*int'(x) -: 4];
    endfunction

    // Three mini-box layers with the middle bit pairs swapped between layers.
    function automatic logic [7:0] sbox(input logic [7:0] u);
        logic [3:0] hi, lo;
        hi = mini_p(u[7:4]);
        lo = mini_q(u[3:0]);
        {hi, lo} = {hi[3:2], lo[3:2], hi[1:0], lo[1:0]};
        hi = mini_q(hi);
        lo = mini_p(lo);
        {hi, lo} = {hi[3:2], lo[3:2], hi[1:0], lo[1:0]};
        return {mini_p(hi), mini_q(lo)};
    endfunction

    for (genvar k = 0; k < BYTES; k++) begin : g_byte
        assign b[8*k+7 -: 8] = sbox(a[8*k+7 -: 8]);
    end
endmodule

// Row-wise multiplication by had(01,02,04,06) over GF(2^8) mod x^8+x^4+x^3+x^2+1, registered.
module theta (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] a,
    output logic [127:0] b
);
    logic [127:0] mix;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] mul_h(input logic [7:0] x, input logic [1:0] sel);
        logic [7:0] x2, x4;
        x2 = xtime(x);
        x4 = xtime(x2);
        case (sel)
            2'd0:    return x;
            2'd1:    return x2;
            2'd2:    return x4;
            default: return x4 ^ x2;
        endcase
    endfunction

    function automatic logic [7:0] mix_byte(input logic [127:0] m, input int i, input int j);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
            acc ^= mul_h(m[127 - 8*(4*i+k) -: 8], 2'(k ^ j));
        return acc;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mix = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mix[127 - 8*(4*i+j) -: 8] = mix_byte(a, i, j);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  b <= '0;
        else if (en) b <= mix;
    end
endmodule

module key_evolution #(
    parameter int SLOT_LEN   = 16,
    parameter int LAST_ROUND = 12
) (
    input  logic             clk,
    input  logic             reset,
    key_evolution_if.slave   bus
);
    localparam logic [3:0] SLOT_END  = 4'(SLOT_LEN - 1);
    localparam logic [3:0] ROUND_END = 4'(LAST_ROUND);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [127:0] ekey;
    logic [3:0]   round_q;
    logic [3:0]   counter_q;
    logic         load_q;
    logic         busy_q;
    logic         done_q;

    logic [127:0] gamma_q, pi_q, theta_q, next_key;
    logic [127:0] gamma_out, theta_out;
    logic [31:0]  rc_in, rc_out;
    logic         theta_en;

    function automatic logic [127:0] pi_rot(input logic [127:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[127 - 8*(4*i+j) -: 8] = m[127 - 8*(4*((i - j + 4) % 4) + j) -: 8];
        return r;
    endfunction

    gamma #(.BYTES(16)) u_gamma (.a(ekey), .b(gamma_out));

    // Round constant row for K^(r+1): S-box of bytes 4r..4r+3.
    assign rc_in = {2'b00, round_q, 2'd0, 2'b00, round_q, 2'd1,
                    2'b00, round_q, 2'd2, 2'b00, round_q, 2'd3};
    gamma #(.BYTES(4)) u_rc (.a(rc_in), .b(rc_out));

    assign theta_en = (state == RUN) && (counter_q == 4'd8);
    theta u_theta (.clk(clk), .reset(reset), .en(theta_en), .a(pi_q), .b(theta_out));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ekey      <= '0;
            round_q   <= '0;
            counter_q <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        ekey      <= bus.cipher_key;
                        round_q   <= '0;
                        counter_q <= '0;
                        load_q    <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    counter_q <= counter_q + 4'd1;
                    if (counter_q == SLOT_END) begin
                        counter_q <= '0;
                        if (round_q == ROUND_END) begin
                            state  <= DONE;
                            load_q <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            ekey    <= next_key;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the pipeline registers are datapath, but they still clear on reset so a
    // reset mid-run can never leak a partial key into the next schedule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gamma_q  <= '0;
            pi_q     <= '0;
            theta_q  <= '0;
            next_key <= '0;
        end else if (state == RUN) begin
            if (counter_q == 4'd2)  gamma_q  <= gamma_out;
            if (counter_q == 4'd5)  pi_q     <= pi_rot(gamma_q);
            if (counter_q == 4'd9)  theta_q  <= theta_out;
            if (counter_q == 4'd12) next_key <= theta_q ^ {rc_out, 96'b0};
        end
    end

    assign bus.evolutioned_key = ekey;
    assign bus.round_num       = round_q;
    assign bus.counter         = counter_q;
    assign bus.load_key        = load_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule
